// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester byte streams and the UART transmitter handshake shared
// by uart_tx_arbiter.
//   master : requester/transmitter side (drives req_*, tx_busy)
//   slave  : arbiter side (drives req_ready, tx_data, tx_flag, grant_*)
// Signals:
//   req_valid[NUM_REQ]    per-requester byte available
//   req_data[8*NUM_REQ]   requester i byte at [8i+7:8i]
//   req_last[NUM_REQ]     final byte of packet, qualified by req_valid
//   req_ready[NUM_REQ]    one-hot one-cycle accept pulse
//   tx_data[8]            byte to transmitter, held until next load
//   tx_flag               one-cycle transmitter start pulse
//   tx_busy               transmitter shifting a frame
//   grant_active          packet grant held
//   grant_id[ID_W]        granted requester index
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_flag;
  logic                 tx_busy;
  logic                 grant_active;
  logic [ID_W-1:0]      grant_id;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_flag, grant_active, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_flag, grant_active, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter and byte sequencer sharing one UART transmitter among
// NUM_REQ byte-stream requesters. A grant is held for a whole packet (until the
// byte flagged req_last has been sent), so packets never interleave. One byte
// is handed to the transmitter per tx_flag pulse, paced by tx_busy.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (requester streams + transmitter handshake)
// Optional build macro UART_ARB_ID_HDR_EN: every packet is preceded by a header
// byte {4'hA, grant_id[3:0]} that the requester never sees accepted.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 4,
  parameter int START_TO = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_TO + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
`ifdef UART_ARB_ID_HDR_EN
    , HDR
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_active_q, grant_active_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_flag_q, tx_flag_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found;
  logic [ID_W-1:0]    pick;
  logic [IDX_W-1:0]   gid_idx;
  logic [ID_W-1:0]    rr_next;
  logic [7:0]         req_byte [NUM_REQ];
  int                 j;

  assign gid_idx = IDX_W'(grant_id_q);
  assign rr_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Round-robin search: first valid index at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && bus.req_valid[IDX_W'(j)]) begin
        found = 1'b1;
        pick  = ID_W'(j);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = bus.req_data[8*i +: 8];
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    req_ready_d    = '0;
    tx_flag_d      = 1'b0;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    cnt_d          = cnt_q;

    unique case (state_q)
      IDLE: begin
        // Never start a packet while the transmitter is still finishing a frame.
        if (found && !bus.tx_busy) begin
          grant_id_d     = pick;
          grant_active_d = 1'b1;
`ifdef UART_ARB_ID_HDR_EN
          state_d        = HDR;
`else
          state_d        = LOAD;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      HDR: begin
        tx_data_d = {4'hA, 4'(grant_id_q)};
        last_d    = 1'b0;
        state_d   = SEND;
      end
`endif
      LOAD: begin
        // The grant stays locked here until the granted requester offers a byte.
        if (bus.req_valid[gid_idx]) begin
          req_ready_d[gid_idx] = 1'b1;
          tx_data_d            = req_byte[gid_idx];
          last_d               = bus.req_last[gid_idx];
          state_d              = SEND;
        end
      end
      SEND: begin
        tx_flag_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // The transmitter gets START_TO cycles, counted from the tx_flag cycle
        // through the following WAIT_DONE cycle, to raise tx_busy; otherwise
        // the byte is taken as sent.
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(START_TO - 2)) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            rr_ptr_d       = rr_next;
            grant_active_d = 1'b0;
            state_d        = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      req_ready_q    <= '0;
      tx_data_q      <= 8'h00;
      tx_flag_q      <= 1'b0;
      last_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      req_ready_q    <= req_ready_d;
      tx_data_q      <= tx_data_d;
      tx_flag_q      <= tx_flag_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_flag      = tx_flag_q;
  assign bus.grant_active = grant_active_q;
  assign bus.grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. Requesters are per-index byte FIFOs that
// pop on req_ready; the transmitter model holds tx_busy for FRAME cycles after
// each tx_flag (or never, when disabled). Build with UART_ARB_ID_HDR_EN to
// expect the header byte ahead of every packet.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 4;
  localparam int START_TO = 16;
  localparam int FRAME    = 8;
`ifdef UART_ARB_ID_HDR_EN
  localparam int H = 1;
  localparam logic [7:0] FIRST_REQ3 = 8'hA3;
`else
  localparam int H = 0;
  localparam logic [7:0] FIRST_REQ3 = 8'hC3;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .START_TO(START_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  int         viol = 0;
  int         busy_cnt = 0;
  int         rdy0_cyc = -1;
  bit         model_en = 1'b1;
  bit         force_busy = 1'b0;
  logic [8:0] pmem [NUM_REQ][16];
  int         head [NUM_REQ];
  int         tail [NUM_REQ];
  logic [7:0] log_q [$];
  logic [7:0] exp_q [$];
  int         flag_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head[i] < tail[i]) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_last[i]         = pmem[i][head[i]][8];
        bus.req_data[8*i +: 8]  = pmem[i][head[i]][7:0];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_last[i]         = 1'b0;
        bus.req_data[8*i +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic push(input int id, input logic [7:0] b, input logic last);
    pmem[id][tail[id]] = {last, b};
    tail[id]++;
    drive();
  endtask

  task automatic exp_hdr(input int id);
    if (H == 1) exp_q.push_back({4'hA, 4'(id)});
  endtask

  // One cycle: observe at the falling edge, update models, re-drive inputs.
  task automatic tick();
    @(negedge clk);
    cycle++;
    if (bus.req_ready != '0 &&
        (bus.req_ready != (NUM_REQ'(1) << bus.grant_id) || !bus.grant_active)) viol++;
    if (bus.req_ready[0] && rdy0_cyc < 0) rdy0_cyc = cycle;
    if (bus.tx_flag) begin
      log_q.push_back(bus.tx_data);
      flag_cyc.push_back(cycle);
      if (model_en) busy_cnt = FRAME;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = force_busy || (busy_cnt != 0);
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.req_ready[i] && head[i] < tail[i]) head[i]++;
    drive();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = !bus.grant_active && !bus.tx_busy;
      for (int i = 0; i < NUM_REQ; i++) if (head[i] < tail[i]) done = 1'b0;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_logs();
    log_q.delete();
    exp_q.delete();
    flag_cyc.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    bus.tx_busy = 1'b0;
    drive();

    // Reset values
    tick();
    tick();
    check("rst_tx_flag",      32'(bus.tx_flag),      32'd0);
    check("rst_req_ready",    32'(bus.req_ready),    32'd0);
    check("rst_tx_data",      32'(bus.tx_data),      32'h00);
    check("rst_grant_active", 32'(bus.grant_active), 32'd0);
    check("rst_grant_id",     32'(bus.grant_id),     32'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: two rounds of one byte from every requester
    clear_logs();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        push(i, 8'hA0 + 8'(i), 1'b1);
        exp_hdr(i);
        exp_q.push_back(8'hA0 + 8'(i));
      end
      wait_idle("fair_idle", 400);
    end
    check_log("fair");

    // Single byte from requester 2
    clear_logs();
    push(2, 8'h55, 1'b1);
    tick();
    check("single_grant_active", 32'(bus.grant_active), 32'd1);
    check("single_grant_id",     32'(bus.grant_id),     32'd2);
    n = 0;
    while (bus.req_ready == '0 && n < 40) begin
      tick();
      n++;
    end
    check("single_req_ready", 32'(bus.req_ready), 32'b0100);
    check("single_tx_data",   32'(bus.tx_data),   32'h55);
    tick();
    check("single_tx_flag",    32'(bus.tx_flag),   32'd1);
    check("single_ready_drop", 32'(bus.req_ready), 32'd0);
    wait_idle("single_idle", 100);
    check("single_released", 32'(bus.grant_active), 32'd0);
    exp_hdr(2);
    exp_q.push_back(8'h55);
    // Search now starts at index 3, ahead of index 1
    push(1, 8'h61, 1'b1);
    push(3, 8'h63, 1'b1);
    tick();
    check("rr_next_grant", 32'(bus.grant_id), 32'd3);
    wait_idle("rr_idle", 200);
    exp_hdr(3);
    exp_q.push_back(8'h63);
    exp_hdr(1);
    exp_q.push_back(8'h61);
    check_log("single_rr");

    // Packet lock: req1 three-byte packet, req0 waits with 0x99
    clear_logs();
    rdy0_cyc = -1;
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    tick();
    check("lock_grant_id", 32'(bus.grant_id), 32'd1);
    push(0, 8'h99, 1'b1);
    wait_idle("lock_idle", 400);
    exp_hdr(1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_hdr(0);
    exp_q.push_back(8'h99);
    check_log("lock");
    if (flag_cyc.size() >= H + 3) begin
      check("lock_byte_gap", 32'(flag_cyc[H+1] - flag_cyc[H]), 32'(FRAME + 3));
      check("lock_req0_ready_cycle", 32'(rdy0_cyc),
            32'(flag_cyc[H+2] + FRAME + 3 + H * (FRAME + 3)));
    end else begin
      check("lock_flag_count", 32'(flag_cyc.size()), 32'(H + 3));
    end

    // Busy gating
    clear_logs();
    force_busy = 1'b1;
    bus.tx_busy = 1'b1;
    push(0, 8'h42, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("gate_grant_active", 32'(bus.grant_active), 32'd0);
      check("gate_req_ready",    32'(bus.req_ready),    32'd0);
      check("gate_tx_flag",      32'(bus.tx_flag),      32'd0);
    end
    force_busy = 1'b0;
    bus.tx_busy = (busy_cnt != 0);
    tick();
    check("gate_release_grant", 32'(bus.grant_active), 32'd1);
    check("gate_release_id",    32'(bus.grant_id),     32'd0);
    wait_idle("gate_idle", 200);
    exp_hdr(0);
    exp_q.push_back(8'h42);
    check_log("gate");

    // Start timeout: transmitter never raises busy
    clear_logs();
    model_en = 1'b0;
    push(2, 8'h01, 1'b0);
    push(2, 8'h82, 1'b1);
    wait_idle("timeout_idle", 300);
    exp_hdr(2);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h82);
    check_log("timeout");
    if (flag_cyc.size() >= H + 2)
      check("timeout_gap", 32'(flag_cyc[H+1] - flag_cyc[H]), 32'(START_TO + 2));
    else
      check("timeout_flag_count", 32'(flag_cyc.size()), 32'(H + 2));
    model_en = 1'b1;

    // Reset while waiting for the frame to finish
    clear_logs();
    push(3, 8'hC3, 1'b1);
    n = 0;
    while (flag_cyc.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    check("mid_first_flag_seen", 32'(flag_cyc.size()), 32'd1);
    if (log_q.size() > 0) check("mid_first_byte", 32'(log_q[0]), 32'(FIRST_REQ3));
    tick();
    tick();
    check("mid_pre_grant_active", 32'(bus.grant_active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_flag",      32'(bus.tx_flag),      32'd0);
    check("mid_rst_req_ready",    32'(bus.req_ready),    32'd0);
    check("mid_rst_grant_active", 32'(bus.grant_active), 32'd0);
    check("mid_rst_grant_id",     32'(bus.grant_id),     32'd0);
    check("mid_rst_tx_data",      32'(bus.tx_data),      32'h00);

    check("ready_only_to_grant", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
